// File: rtl/spi_lcd_pkg.sv
// Shared types and constants for the SPI LCD transmit path.
package spi_lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int DEFAULT_DATA_W = 16;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_lcd_tx_if.sv
// Handshake and panel-pin bundle for spi_lcd_tx.
// Define SPI_READBACK_EN to add the i_miso / o_rdata readback signals.
interface spi_lcd_tx_if
    import spi_lcd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [DATA_W-1:0] i_data;
    logic              i_dc;
    logic              i_valid;
    logic              o_ready;
    logic              o_sclk;
    logic              o_mosi;
    logic              o_cs;
    logic              o_dc;
    logic              o_done;
`ifdef SPI_READBACK_EN
    logic              i_miso;
    logic [DATA_W-1:0] o_rdata;

    modport master (
        input  i_data, i_dc, i_valid, i_miso,
        output o_ready, o_sclk, o_mosi, o_cs, o_dc, o_done, o_rdata
    );

    modport slave (
        output i_data, i_dc, i_valid, i_miso,
        input  o_ready, o_sclk, o_mosi, o_cs, o_dc, o_done, o_rdata
    );
`else
    modport master (
        input  i_data, i_dc, i_valid,
        output o_ready, o_sclk, o_mosi, o_cs, o_dc, o_done
    );

    modport slave (
        output i_data, i_dc, i_valid,
        input  o_ready, o_sclk, o_mosi, o_cs, o_dc, o_done
    );
`endif
endinterface

// File: rtl/spi_clk_div.sv
// SCLK timing generator: half-period ticks split into lead-edge and bit-boundary pulses.
module spi_clk_div
    import spi_lcd_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic enable,
    output logic half_tick,
    output logic lead_pulse,
    output logic bit_end
);
    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase;

    // phase 0 is the idle half of a bit, phase 1 the active half
    always_ff @(posedge i_clk) begin
        if (i_rst || !enable) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (half_tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign half_tick  = enable && (div_cnt == DIV_LAST);
    assign lead_pulse = half_tick && !phase;
    assign bit_end    = half_tick && phase;

endmodule

// File: rtl/spi_lcd_tx.sv
// SPI transmit engine for LCD/SD panels: one CS-framed word per handshake, then a CS-high gap.
// Define SPI_READBACK_EN to capture MISO into o_rdata.
module spi_lcd_tx
    import spi_lcd_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int CLK_DIV   = 1,
    parameter int WAIT      = 10,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit CPOL      = 1'b0
) (
    input logic          i_clk,
    input logic          i_rst,
    spi_lcd_tx_if.master bus
);
    localparam int BIT_W   = cnt_width(DATA_W);
    localparam int GAP_W   = cnt_width(WAIT);
    localparam bit HAS_GAP = (WAIT > 0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HAS_GAP ? WAIT - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              dc_q;
    logic              sclk_q;
    logic              half_tick;
    logic              lead_pulse;
    logic              bit_end;
    logic              accept;
    logic              last_bit;
    logic              gap_end;
    logic              tx_bit;
    logic              shifting;

    assign shifting = (state == SHIFT);
    assign accept   = bus.i_valid && (state == IDLE);
    assign last_bit = shifting && bit_end && (bit_cnt == BIT_LAST);
    assign gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);
    assign tx_bit   = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .enable     (shifting),
        .half_tick  (half_tick),
        .lead_pulse (lead_pulse),
        .bit_end    (bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = HAS_GAP ? GAP : DONE;
            GAP:     if (gap_end)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifter only advances on bit boundaries, so MOSI is stable across each lead edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            dc_q    <= DC_CMD;
        end else begin
            if (accept) begin
                shreg   <= bus.i_data;
                dc_q    <= bus.i_dc;
                bit_cnt <= '0;
            end else if (shifting && bit_end) begin
                shreg   <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            if (state == GAP) begin
                gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_q <= CPOL;
        end else if (half_tick) begin
            sclk_q <= lead_pulse ? ~CPOL : CPOL;
        end else if (!shifting) begin
            sclk_q <= CPOL;
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_cs    = !shifting;
    assign bus.o_sclk  = sclk_q;
    assign bus.o_mosi  = shifting && tx_bit;
    assign bus.o_dc    = dc_q;
    assign bus.o_done  = (state == DONE);

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rx_shreg;
    logic [DATA_W-1:0] rdata_q;

    // MISO is captured on the same lead edge the slave uses, in MOSI bit order
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_shreg <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                rx_shreg <= '0;
            end else if (shifting && lead_pulse) begin
                rx_shreg <= MSB_FIRST ? {rx_shreg[DATA_W-2:0], bus.i_miso}
                                      : {bus.i_miso, rx_shreg[DATA_W-1:1]};
            end
            if (state_next == DONE) begin
                rdata_q <= rx_shreg;
            end
        end
    end

    assign bus.o_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_spi_lcd_tx.sv
// Directed scoreboard bench for spi_lcd_tx across three parameter sets.
// Define SPI_READBACK_EN to also check MISO readback on the default instance.
module tb_spi_lcd_tx;
    import spi_lcd_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] drv_data;
    logic        drv_dc;
    logic        drv_valid;
    int          sel;
    logic        m_sclk, m_mosi, m_cs, m_dc, m_done, m_ready;
    logic        m_cpol;
    logic        m_msb;
    int          m_w;
    int          n_compared;
    int          n_mismatch;
    logic [31:0] exp_q[$];
    int          done_cyc[$];
    int          cs_fall_cyc[$];
    int          cs_rise_cyc[$];
    int          sclk_toggles;
    int          ready_cyc;
    int          idle_err;
    int          done_count;
    logic        dc_hist [0:199];
`ifdef SPI_READBACK_EN
    logic        miso_drv;
    logic [15:0] echo_word;
    logic [15:0] rdata_at_done;
`endif

    spi_lcd_tx_if #(.DATA_W(16)) bus_a ();
    spi_lcd_tx_if #(.DATA_W(8))  bus_b ();
    spi_lcd_tx_if #(.DATA_W(16)) bus_c ();

    spi_lcd_tx dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_a));

    spi_lcd_tx #(
        .DATA_W(8), .CLK_DIV(3), .WAIT(10), .MSB_FIRST(1'b0), .CPOL(1'b1)
    ) dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_b));

    spi_lcd_tx #(.WAIT(0)) dut_c (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_c));

    assign bus_a.i_data  = drv_data[15:0];
    assign bus_a.i_dc    = drv_dc;
    assign bus_a.i_valid = drv_valid && (sel == 0);
    assign bus_b.i_data  = drv_data[7:0];
    assign bus_b.i_dc    = drv_dc;
    assign bus_b.i_valid = drv_valid && (sel == 1);
    assign bus_c.i_data  = drv_data[15:0];
    assign bus_c.i_dc    = drv_dc;
    assign bus_c.i_valid = drv_valid && (sel == 2);
`ifdef SPI_READBACK_EN
    assign bus_a.i_miso = miso_drv;
    assign bus_b.i_miso = 1'b0;
    assign bus_c.i_miso = 1'b0;
`endif

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always_comb begin
        m_sclk  = bus_a.o_sclk;
        m_mosi  = bus_a.o_mosi;
        m_cs    = bus_a.o_cs;
        m_dc    = bus_a.o_dc;
        m_done  = bus_a.o_done;
        m_ready = bus_a.o_ready;
        case (sel)
            1: begin
                m_sclk  = bus_b.o_sclk;
                m_mosi  = bus_b.o_mosi;
                m_cs    = bus_b.o_cs;
                m_dc    = bus_b.o_dc;
                m_done  = bus_b.o_done;
                m_ready = bus_b.o_ready;
            end
            2: begin
                m_sclk  = bus_c.o_sclk;
                m_mosi  = bus_c.o_mosi;
                m_cs    = bus_c.o_cs;
                m_dc    = bus_c.o_dc;
                m_done  = bus_c.o_done;
                m_ready = bus_c.o_ready;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic selectDut(input int s);
        sel = s;
        m_cpol = (s == 1);
        m_msb  = (s != 1);
        m_w    = (s == 1) ? 8 : 16;
    endtask

    // Drives one request and returns just after the accepting edge (start of cycle 1)
    task automatic applyStimulus(input logic [31:0] data, input logic dc, input bit push);
        @(negedge i_clk);
        drv_data  = data;
        drv_dc    = dc;
        drv_valid = 1'b1;
        if (push) exp_q.push_back(data);
        @(posedge i_clk);
        #1;
    endtask

    // Samples one cycle per falling clock edge, reassembling MOSI words on lead SCLK edges
    task automatic observe(input int ncycles, input int drop_at, input int pulse_at,
                           input logic [31:0] pulse_data);
        logic [31:0] rx_word;
        logic [31:0] expd;
        int          rx_bits;
        logic        prev_sclk, prev_cs, prev_ready;
        rx_word = '0;
        rx_bits = 0;
        prev_sclk = m_cpol;
        prev_cs = 1'b1;
        prev_ready = 1'b1;
        done_cyc.delete();
        cs_fall_cyc.delete();
        cs_rise_cyc.delete();
        sclk_toggles = 0;
        ready_cyc = -1;
        idle_err = 0;
        for (int c = 1; c <= ncycles; c++) begin
            @(negedge i_clk);
            if (c == drop_at) drv_valid = 1'b0;
            if (c == pulse_at) begin
                drv_valid = 1'b1;
                drv_data  = pulse_data;
            end
            if (c == pulse_at + 1) drv_valid = 1'b0;
            if (c < 200) dc_hist[c] = m_dc;
            if (m_sclk !== prev_sclk) sclk_toggles++;
            if (m_cs && (m_sclk !== m_cpol)) idle_err++;
            if (!m_cs && (m_sclk === ~m_cpol) && (prev_sclk === m_cpol)) begin
                if (m_msb) rx_word = {rx_word[30:0], m_mosi};
                else       rx_word = (rx_word >> 1) | ({31'b0, m_mosi} << (m_w - 1));
                rx_bits++;
            end
`ifdef SPI_READBACK_EN
            if (sel == 0 && !m_cs && (m_sclk === m_cpol) && rx_bits < 16)
                miso_drv = echo_word[15 - rx_bits];
            if (sel == 0 && m_done) rdata_at_done = bus_a.o_rdata;
`endif
            if (!m_cs && prev_cs) cs_fall_cyc.push_back(c);
            if (m_cs && !prev_cs) begin
                cs_rise_cyc.push_back(c);
                expd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                checkOutput("sb_word", rx_word, expd);
                checkOutput("sb_bits", rx_bits, m_w);
                rx_word = '0;
                rx_bits = 0;
            end
            if (m_done) done_cyc.push_back(c);
            if (m_ready && !prev_ready && ready_cyc < 0) ready_cyc = c;
            prev_sclk  = m_sclk;
            prev_cs    = m_cs;
            prev_ready = m_ready;
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatch = 0;
        drv_data = '0;
        drv_dc = 1'b0;
        drv_valid = 1'b0;
`ifdef SPI_READBACK_EN
        miso_drv = 1'b0;
        echo_word = 16'h3C96;
        rdata_at_done = '0;
`endif
        selectDut(0);
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        $display("[TB] reset state");
        for (int s = 0; s < 2; s++) begin
            selectDut(s);
            #1;
            checkOutput("rst_cs", m_cs, 1'b1);
            checkOutput("rst_sclk", m_sclk, m_cpol);
            checkOutput("rst_mosi", m_mosi, 1'b0);
            checkOutput("rst_dc", m_dc, 1'b0);
            checkOutput("rst_done", m_done, 1'b0);
            checkOutput("rst_ready", m_ready, 1'b1);
        end
`ifdef SPI_READBACK_EN
        checkOutput("rst_rdata", bus_a.o_rdata, 16'h0000);
`endif

        $display("[TB] default config, A5C3 data word");
        selectDut(0);
        applyStimulus(32'h0000_A5C3, DC_DATA, 1'b1);
        observe(50, 1, -1, '0);
        checkOutput("t1_cs_fall", qget(cs_fall_cyc, 0), 1);
        checkOutput("t1_cs_rise", qget(cs_rise_cyc, 0), 33);
        checkOutput("t1_toggles", sclk_toggles, 32);
        checkOutput("t1_done_n", done_cyc.size(), 1);
        checkOutput("t1_done_cyc", qget(done_cyc, 0), 43);
        checkOutput("t1_ready_cyc", ready_cyc, 44);
        checkOutput("t1_idle_sclk", idle_err, 0);
        checkOutput("t1_dc", m_dc, 1'b1);
`ifdef SPI_READBACK_EN
        checkOutput("t1_rdata_done", rdata_at_done, 16'h3C96);
        checkOutput("t1_rdata_held", bus_a.o_rdata, 16'h3C96);
`endif

        $display("[TB] 8-bit LSB-first, CPOL=1, CLK_DIV=3");
        selectDut(1);
        applyStimulus(32'h0000_0081, DC_CMD, 1'b1);
        observe(70, 1, -1, '0);
        checkOutput("t2_cs_rise", qget(cs_rise_cyc, 0), 49);
        checkOutput("t2_toggles", sclk_toggles, 16);
        checkOutput("t2_done_cyc", qget(done_cyc, 0), 59);
        checkOutput("t2_ready_cyc", ready_cyc, 60);
        checkOutput("t2_idle_sclk", idle_err, 0);
        applyStimulus(32'h0000_000E, DC_DATA, 1'b1);
        observe(70, 1, -1, '0);
        checkOutput("t2b_done_cyc", qget(done_cyc, 0), 59);

        $display("[TB] back-to-back with WAIT=0");
        selectDut(2);
        applyStimulus(32'h0000_0001, DC_DATA, 1'b1);
        drv_data = 32'h0000_8000;
        drv_dc = DC_CMD;
        exp_q.push_back(32'h0000_8000);
        observe(80, 35, -1, '0);
        checkOutput("t3_done_n", done_cyc.size(), 2);
        checkOutput("t3_done0", qget(done_cyc, 0), 33);
        checkOutput("t3_done1", qget(done_cyc, 1), 67);
        checkOutput("t3_cs_gap", qget(cs_fall_cyc, 1) - qget(cs_rise_cyc, 0), 2);
        checkOutput("t3_dc_before", dc_hist[34], 1'b1);
        checkOutput("t3_dc_after", dc_hist[35], 1'b0);

        $display("[TB] reset mid-transaction");
        selectDut(0);
        applyStimulus(32'h0000_1234, DC_DATA, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge i_clk);
            if (c == 1) drv_valid = 1'b0;
            if (c == 10) i_rst = 1'b1;
        end
        @(negedge i_clk);
        checkOutput("t4_cs", m_cs, 1'b1);
        checkOutput("t4_sclk", m_sclk, 1'b0);
        checkOutput("t4_ready", m_ready, 1'b1);
        checkOutput("t4_done", m_done, 1'b0);
`ifdef SPI_READBACK_EN
        checkOutput("t4_rdata", bus_a.o_rdata, 16'h0000);
`endif
        i_rst = 1'b0;
        done_count = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            if (m_done) done_count++;
        end
        checkOutput("t4_no_done", done_count, 0);
        applyStimulus(32'h0000_5A0F, DC_CMD, 1'b1);
        observe(50, 1, -1, '0);
        checkOutput("t4_fresh_done", qget(done_cyc, 0), 43);
        checkOutput("t4_fresh_dc", m_dc, 1'b0);

        $display("[TB] valid pulse during SHIFT is ignored");
        applyStimulus(32'h0000_3C3C, DC_DATA, 1'b1);
        observe(60, 1, 8, 32'h0000_FFFF);
        checkOutput("t5_done_n", done_cyc.size(), 1);
        checkOutput("t5_done_cyc", qget(done_cyc, 0), 43);
        checkOutput("t5_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
